// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one fetch outstanding to instruction memory,
// and feeds the IF/ID register. A skid entry absorbs a response that lands during a stall.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_take_branch_in,
  input  logic [31:0] ex_target_PC_in,
  input  logic        if_stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] if_PC_out,
  output logic [31:0] if_NPC_out,
  output logic [31:0] if_IR_out,
  output logic        if_valid_inst_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_r, state_nx_s;
  logic [31:0] pc_r, pc_nx_s;
  logic [31:0] req_pc_r, req_pc_nx_s;
  logic        squash_r, squash_nx_s;
  logic [31:0] skid_pc_r, skid_pc_nx_s;
  logic [31:0] skid_ir_r, skid_ir_nx_s;
  logic [31:0] out_pc_r, out_pc_nx_s;
  logic [31:0] out_npc_r, out_npc_nx_s;
  logic [31:0] out_ir_r, out_ir_nx_s;
  logic        out_valid_r, out_valid_nx_s;
  logic        load_s;
  logic [31:0] load_pc_s;
  logic [31:0] load_ir_s;
  logic [31:0] target_s;

  assign target_s       = {ex_target_PC_in[31:2], 2'b00};
  // Request is suppressed while held in reset so the bus stays quiet
  assign imem_req_valid = (state_r == S_REQ) && !ex_take_branch_in && !rst;
  assign imem_req_addr  = pc_r;

  assign if_PC_out         = out_pc_r;
  assign if_NPC_out        = out_npc_r;
  assign if_IR_out         = out_ir_r;
  assign if_valid_inst_out = out_valid_r;

  // Next-state, PC and slot-load selection
  always_comb begin
    state_nx_s   = state_r;
    pc_nx_s      = pc_r;
    req_pc_nx_s  = req_pc_r;
    squash_nx_s  = squash_r;
    skid_pc_nx_s = skid_pc_r;
    skid_ir_nx_s = skid_ir_r;
    load_s       = 1'b0;
    load_pc_s    = req_pc_r;
    load_ir_s    = imem_rsp_data;
    case (state_r)
      S_REQ: begin
        if (ex_take_branch_in) begin
          pc_nx_s = target_s;
        end else if (imem_req_ready) begin
          state_nx_s  = S_WAIT;
          req_pc_nx_s = pc_r;
        end else begin
          state_nx_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (ex_take_branch_in) begin
          pc_nx_s = target_s;
          if (imem_rsp_valid) begin
            state_nx_s  = S_REQ;
            squash_nx_s = 1'b0;
          end else begin
            squash_nx_s = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (squash_r) begin
            squash_nx_s = 1'b0;
            state_nx_s  = S_REQ;
          end else if (!out_valid_r || !if_stall) begin
            load_s     = 1'b1;
            pc_nx_s    = req_pc_r + 32'd4;
            state_nx_s = S_REQ;
          end else begin
            skid_pc_nx_s = req_pc_r;
            skid_ir_nx_s = imem_rsp_data;
            state_nx_s   = S_HOLD;
          end
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (ex_take_branch_in) begin
          pc_nx_s    = target_s;
          state_nx_s = S_REQ;
        end else if (!if_stall) begin
          load_s     = 1'b1;
          load_pc_s  = skid_pc_r;
          load_ir_s  = skid_ir_r;
          pc_nx_s    = skid_pc_r + 32'd4;
          state_nx_s = S_REQ;
        end else begin
          state_nx_s = S_HOLD;
        end
      end
      default: begin
        state_nx_s = S_REQ;
      end
    endcase
  end

  // IF/ID slot update: redirect kills, load fills, consumption empties, stall holds
  always_comb begin
    out_pc_nx_s    = out_pc_r;
    out_npc_nx_s   = out_npc_r;
    out_ir_nx_s    = out_ir_r;
    out_valid_nx_s = out_valid_r;
    if (ex_take_branch_in) begin
      out_valid_nx_s = 1'b0;
      out_ir_nx_s    = NOP_INST;
    end else if (load_s) begin
      out_valid_nx_s = 1'b1;
      out_pc_nx_s    = load_pc_s;
      out_npc_nx_s   = load_pc_s + 32'd4;
      out_ir_nx_s    = load_ir_s;
    end else if (!if_stall) begin
      out_valid_nx_s = 1'b0;
      out_ir_nx_s    = NOP_INST;
    end else begin
      out_valid_nx_s = out_valid_r;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_REQ;
      pc_r        <= RESET_PC;
      req_pc_r    <= RESET_PC;
      squash_r    <= 1'b0;
      skid_pc_r   <= 32'h0000_0000;
      skid_ir_r   <= NOP_INST;
      out_pc_r    <= 32'h0000_0000;
      out_npc_r   <= 32'h0000_0000;
      out_ir_r    <= NOP_INST;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      pc_r        <= pc_nx_s;
      req_pc_r    <= req_pc_nx_s;
      squash_r    <= squash_nx_s;
      skid_pc_r   <= skid_pc_nx_s;
      skid_ir_r   <= skid_ir_nx_s;
      out_pc_r    <= out_pc_nx_s;
      out_npc_r   <= out_npc_nx_s;
      out_ir_r    <= out_ir_nx_s;
      out_valid_r <= out_valid_nx_s;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a 1-cycle memory model, a scoreboard of accepted
// fetches, and a second instance with a wrap-around reset PC.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_take_branch_in;
  logic [31:0] ex_target_PC_in;
  logic        if_stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] if_PC_out, if_NPC_out, if_IR_out;
  logic        if_valid_inst_out;

  logic        u1_req_valid;
  logic [31:0] u1_req_addr, u1_pc, u1_npc, u1_ir;
  logic        u1_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } sb_t;

  sb_t         sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        auto_rsp;
  logic        ovr_en;
  logic [31:0] ovr_data;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) u0 (
    .clk(clk), .rst(rst), .ex_take_branch_in(ex_take_branch_in), .ex_target_PC_in(ex_target_PC_in),
    .if_stall(if_stall), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_PC_out(if_PC_out), .if_NPC_out(if_NPC_out), .if_IR_out(if_IR_out),
    .if_valid_inst_out(if_valid_inst_out));

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) u1 (
    .clk(clk), .rst(rst), .ex_take_branch_in(ex_take_branch_in), .ex_target_PC_in(ex_target_PC_in),
    .if_stall(if_stall), .imem_req_valid(u1_req_valid), .imem_req_addr(u1_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_PC_out(u1_pc), .if_NPC_out(u1_npc), .if_IR_out(u1_ir), .if_valid_inst_out(u1_valid));

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    mem_data = ovr_en ? ovr_data : (a + 32'h0000_00A0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record handshake, advance, drive the memory response, score new presentations
  task automatic tick();
    logic        hs, br, prev_valid, prev_stall;
    logic [31:0] hs_data;
    sb_t         e;
    #1;
    hs         = imem_req_valid && imem_req_ready;
    br         = ex_take_branch_in;
    prev_valid = if_valid_inst_out;
    prev_stall = if_stall;
    hs_data    = mem_data(imem_req_addr);
    if (br) sbq.delete();
    if (hs) sbq.push_back('{pc: imem_req_addr, ir: hs_data});
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      imem_rsp_valid = hs;
      imem_rsp_data  = hs ? hs_data : 32'h0000_0000;
    end
    #1;
    if (if_valid_inst_out && (!prev_stall || !prev_valid)) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sbq.pop_front();
        check("sb_pc", if_PC_out, e.pc);
        check("sb_npc", if_NPC_out, e.pc + 32'd4);
        check("sb_ir", if_IR_out, e.ir);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ex_take_branch_in = 1'b0; ex_target_PC_in = 32'h0; if_stall = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    auto_rsp = 1'b1; ovr_en = 1'b0; ovr_data = 32'h0;
    #2;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_pc", if_PC_out, 32'h0);
    check("rst_npc", if_NPC_out, 32'h0);
    check("rst_ir", if_IR_out, NOP);
    check("rst_valid", {31'd0, if_valid_inst_out}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;

    // 1: back-to-back fetches, one instruction every second cycle
    for (int i = 0; i < 4; i++) begin
      check("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("t1_req_addr", imem_req_addr, 32'(i * 4));
      tick();
      check("t1_wait_valid", {31'd0, if_valid_inst_out}, 32'd0);
      tick();
      check("t1_pres_valid", {31'd0, if_valid_inst_out}, 32'd1);
      check("t1_pres_ir", if_IR_out, 32'h0000_00A0 + 32'(i * 4));
    end

    // 2: memory not ready for 5 cycles at PC 0x10
    imem_req_ready = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      check("t2_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("t2_req_addr", imem_req_addr, 32'h10);
      tick();
    end
    imem_req_ready = 1'b1; #1;
    check("t2_accept_addr", imem_req_addr, 32'h10);
    tick();
    check("t2_in_wait", {31'd0, imem_req_valid}, 32'd0);
    tick();

    // 3: response lands while slot full and stalled -> skid, frozen outputs
    if_stall = 1'b1; ovr_en = 1'b1; ovr_data = 32'h0000_00BB; #1;
    tick();
    ovr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t3_no_req", {31'd0, imem_req_valid}, 32'd0);
      check("t3_frozen_pc", if_PC_out, 32'h10);
      check("t3_frozen_ir", if_IR_out, 32'h0000_00B0);
      check("t3_frozen_valid", {31'd0, if_valid_inst_out}, 32'd1);
    end
    if_stall = 1'b0; #1;
    tick();
    check("t3_skid_ir", if_IR_out, 32'h0000_00BB);
    check("t3_next_req", {31'd0, imem_req_valid}, 32'd1);
    check("t3_next_addr", imem_req_addr, 32'h18);

    // 4: redirect during WAIT, stale response two cycles later
    auto_rsp = 1'b0; imem_rsp_valid = 1'b0;
    tick();
    ex_take_branch_in = 1'b1; ex_target_PC_in = 32'h0000_0103; #1;
    check("t4_req_gated", {31'd0, imem_req_valid}, 32'd0);
    tick();
    ex_take_branch_in = 1'b0;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0; #1;
    check("t4_drop_valid", {31'd0, if_valid_inst_out}, 32'd0);
    check("t4_drop_ir", if_IR_out, NOP);
    check("t4_new_addr", imem_req_addr, 32'h100);
    auto_rsp = 1'b1;
    tick();
    tick();

    // 5: redirect and stall together with a valid slot
    check("t5_slot_valid", {31'd0, if_valid_inst_out}, 32'd1);
    ex_take_branch_in = 1'b1; ex_target_PC_in = 32'h0000_0200; if_stall = 1'b1; #1;
    tick();
    check("t5_kill_valid", {31'd0, if_valid_inst_out}, 32'd0);
    check("t5_kill_ir", if_IR_out, NOP);
    ex_take_branch_in = 1'b0; if_stall = 1'b0; #1;
    check("t5_target_addr", imem_req_addr, 32'h200);
    tick();
    tick();

    // 6: reset mid-WAIT, late response ignored, wrap-around reset PC on u1
    auto_rsp = 1'b0; imem_rsp_valid = 1'b0;
    tick();
    rst = 1'b1; #1;
    sbq.delete();
    check("t6_rst_valid", {31'd0, if_valid_inst_out}, 32'd0);
    check("t6_rst_ir", if_IR_out, NOP);
    check("t6_rst_pc", if_PC_out, 32'h0);
    check("t6_rst_req", {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0BAD; #1;
    check("t6_req_addr", imem_req_addr, 32'h0);
    check("t6_u1_req_addr", u1_req_addr, 32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1'b0; #1;
    check("t6_late_ignored", {31'd0, if_valid_inst_out}, 32'd0);
    check("t6_u1_late_ignored", {31'd0, u1_valid}, 32'd0);
    imem_req_ready = 1'b1; auto_rsp = 1'b1; #1;
    tick();
    tick();
    check("t6_u1_pc", u1_pc, 32'hFFFF_FFFC);
    check("t6_u1_npc_wrap", u1_npc, 32'h0);
    check("t6_u1_ir", u1_ir, 32'h0000_00A0);
    check("t6_u1_second_addr", u1_req_addr, 32'h0);
    check("t6_u0_second_addr", imem_req_addr, 32'h4);
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
